touch_adc_spi: RTL and testbench

- Upstream front-end for the touch-panel UI stage.
- Drives the 3-wire serial interface of the LTM panel's ADS7843-class touch ADC.
- Debounces pen-down, runs X/Y 8-bit conversions while the pen is down, and publishes x/y with a per-sample strobe (penirq_n_o) and a session enable (transmit_en).
- The UI stage counts penirq_n_o falling edges while transmit_en is high, and latches hit/release coordinates from x/y.

---
 rtl/touch_adc_spi.sv | 230 +++++++++++++++++++++++
 tb/tb_touch_adc_spi.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_adc_spi.sv
// touch_adc_spi
//   Front end for the LTM panel's ADS7843-class touch ADC. Debounces pen-down,
//   runs back-to-back X/Y 8-bit conversion frames over the 3-wire serial link
//   while the pen stays down, and publishes each coordinate pair to the UI stage.
//
// Ports
//   sys_clk       in   system clock
//   iRST_n        in   asynchronous active-low reset
//   adc_penirq_n  in   raw pen interrupt from the ADC (asynchronous)
//   adc_dout      in   ADC serial data out
//   adc_dclk      out  ADC serial clock (idles low)
//   adc_din       out  ADC serial command in
//   adc_cs_n      out  ADC chip select (active low)
//   x, y          out  latest coordinates (inversion applied)
//   new_coord_r   out  one-cycle pulse in the cycle x/y change
//   penirq_n_o    out  PULSE_W-cycle low strobe, once per published sample
//   transmit_en   out  high for the whole touch session
//   fsm_state     out  current FSM state, for debug/checkers
//
// Output signalling: there is no backpressure. new_coord_r is a one-cycle
// "valid" with x/y stable in that cycle and held until the next pulse;
// penirq_n_o falls exactly one cycle after each new_coord_r pulse.

module touch_adc_spi #(
  parameter int CLK_DIV    = 4,
  parameter int DEBOUNCE   = 1000,
  parameter int RELEASE    = 1000,
  parameter int SAMPLE_GAP = 5000,
  parameter int PULSE_W    = 16,
  parameter int INV_X      = 0,
  parameter int INV_Y      = 0
) (
  input  logic       sys_clk,
  input  logic       iRST_n,
  input  logic       adc_penirq_n,
  input  logic       adc_dout,
  output logic       adc_dclk,
  output logic       adc_din,
  output logic       adc_cs_n,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       new_coord_r,
  output logic       penirq_n_o,
  output logic       transmit_en,
  output logic [2:0] fsm_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DEBOUNCE = 3'd1;
  localparam logic [2:0] S_CONV_X   = 3'd2;
  localparam logic [2:0] S_CONV_Y   = 3'd3;
  localparam logic [2:0] S_PUBLISH  = 3'd4;
  localparam logic [2:0] S_GAP      = 3'd5;

  localparam logic [7:0] CMD_X = 8'hD8;
  localparam logic [7:0] CMD_Y = 8'h98;

  // Counters are sized to hold their parameter value itself, so that a
  // power-of-two parameter still fits.
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int DEB_W = $clog2(DEBOUNCE + 1);
  localparam int REL_W = $clog2(RELEASE + 1);
  localparam int GAP_W = $clog2(SAMPLE_GAP + 1);
  localparam int PW_W  = $clog2(PULSE_W + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE);
  localparam logic [REL_W-1:0] REL_MAX  = REL_W'(RELEASE);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SAMPLE_GAP - 1);
  localparam logic [PW_W-1:0]  PW_LAST  = PW_W'(PULSE_W - 1);

  // A frame is counted in DCLK half-periods (each CLK_DIV cycles long):
  //   half 0        : CS low, DCLK low, command MSB set up
  //   odd halves    : DCLK high (rising edge k at half 2k-1)
  //   even halves   : DCLK low  (falling edge k at half 2k)
  //   halves 33, 34 : padding period; CS already high, rising edge 17 at 33
  // The padding period doubles as the 2*CLK_DIV CS-high gap between X and Y.
  localparam logic [5:0] HALF_LAST   = 6'd34;
  localparam logic [5:0] HALF_CS_OFF = 6'd33;
  localparam logic [5:0] HALF_CMD_END = 6'd16;
  localparam logic [5:0] HALF_D7     = 6'd19;

  logic [1:0]       pen_sync;
  logic             pen_dn;
  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic [5:0]       half_cnt;
  logic [5:0]       half_nxt;
  logic [DEB_W-1:0] deb_cnt;
  logic [REL_W-1:0] rel_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [PW_W-1:0]  strobe_cnt;
  logic [7:0]       shreg;
  logic [7:0]       raw_x;
  logic [7:0]       cmd;

  assign pen_dn    = ~pen_sync[1];
  assign half_nxt  = half_cnt + 6'd1;
  assign cmd       = (state == S_CONV_X) ? CMD_X : CMD_Y;
  assign fsm_state = state;

  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) pen_sync <= 2'b11;
    else         pen_sync <= {pen_sync[0], adc_penirq_n};
  end

  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      state       <= S_IDLE;
      div_cnt     <= '0;
      half_cnt    <= '0;
      deb_cnt     <= '0;
      rel_cnt     <= '0;
      gap_cnt     <= '0;
      strobe_cnt  <= '0;
      shreg       <= '0;
      raw_x       <= '0;
      adc_dclk    <= 1'b0;
      adc_din     <= 1'b0;
      adc_cs_n    <= 1'b1;
      x           <= '0;
      y           <= '0;
      new_coord_r <= 1'b0;
      penirq_n_o  <= 1'b1;
      transmit_en <= 1'b0;
    end else begin
      new_coord_r <= 1'b0;

      if (strobe_cnt != '0) strobe_cnt <= strobe_cnt - 1'b1;
      else                  penirq_n_o <= 1'b1;

      case (state)
        S_IDLE: begin
          deb_cnt <= '0;
          if (pen_dn) begin
            deb_cnt <= DEB_W'(1);
            state   <= S_DEBOUNCE;
          end
        end

        S_DEBOUNCE: begin
          if (!pen_dn) begin
            deb_cnt <= '0;
            state   <= S_IDLE;
          end else if (deb_cnt >= DEB_MAX - 1'b1) begin
            deb_cnt  <= DEB_MAX;
            div_cnt  <= '0;
            half_cnt <= '0;
            adc_cs_n <= 1'b0;
            adc_dclk <= 1'b0;
            adc_din  <= CMD_X[7];
            state    <= S_CONV_X;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end

        S_CONV_X, S_CONV_Y: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (half_cnt == HALF_LAST) begin
              if (state == S_CONV_X) begin
                raw_x    <= shreg;
                half_cnt <= '0;
                adc_cs_n <= 1'b0;
                adc_dclk <= 1'b0;
                adc_din  <= CMD_Y[7];
                state    <= S_CONV_Y;
              end else begin
                // x, y, new_coord_r and transmit_en all become visible in
                // the PUBLISH cycle.
                x           <= (INV_X != 0) ? (8'hFF - raw_x) : raw_x;
                y           <= (INV_Y != 0) ? (8'hFF - shreg) : shreg;
                new_coord_r <= 1'b1;
                transmit_en <= 1'b1;
                state       <= S_PUBLISH;
              end
            end else begin
              half_cnt <= half_nxt;
              adc_dclk <= half_nxt[0];
              adc_cs_n <= (half_nxt >= HALF_CS_OFF);
              // Command bits move only on falling edges; zero after bit 0.
              if (!half_nxt[0])
                adc_din <= (half_nxt < HALF_CMD_END) ? cmd[3'd7 - half_nxt[3:1]] : 1'b0;
              // Rising edges 10..17 carry D7..D0.
              if (half_nxt[0] && (half_nxt >= HALF_D7))
                shreg <= {shreg[6:0], adc_dout};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_PUBLISH: begin
          penirq_n_o <= 1'b0;
          strobe_cnt <= PW_LAST;
          gap_cnt    <= '0;
          rel_cnt    <= '0;
          state      <= S_GAP;
        end

        S_GAP: begin
          if (pen_dn)                rel_cnt <= '0;
          else if (rel_cnt != REL_MAX) rel_cnt <= rel_cnt + 1'b1;

          if (!pen_dn && (rel_cnt >= REL_MAX - 1'b1)) begin
            transmit_en <= 1'b0;
            state       <= S_IDLE;
          end else if (gap_cnt == GAP_LAST) begin
            // Gap expired: a pen that is up but not yet released just
            // parks here until it comes back down or times out.
            if (pen_dn) begin
              div_cnt  <= '0;
              half_cnt <= '0;
              adc_cs_n <= 1'b0;
              adc_dclk <= 1'b0;
              adc_din  <= CMD_X[7];
              state    <= S_CONV_X;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_touch_adc_spi.sv
// tb_touch_adc_spi
//   Bench for touch_adc_spi. Two instances run in lockstep from the same pen
//   and ADC model: dut (no inversion) and dut_inv (INV_X=1, INV_Y=0).
//   A behavioural ADC model answers each frame from a table of raw X/Y values.

module tb_touch_adc_spi;

  localparam int CLK_DIV    = 2;
  localparam int DEBOUNCE   = 8;
  localparam int RELEASE    = 50;
  localparam int SAMPLE_GAP = 200;
  localparam int PULSE_W    = 16;
  localparam int PERIOD     = 2 * 35 * CLK_DIV + 1 + SAMPLE_GAP;
  localparam int NV         = 5;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] ry;
    logic [7:0] ex;
    logic [7:0] ey;
    logic [7:0] exi;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic iRST_n;
  logic adc_penirq_n;
  logic adc_dout;

  always #5 sys_clk = ~sys_clk;

  logic       adc_dclk, adc_din, adc_cs_n, new_coord_r, penirq_n_o, transmit_en;
  logic [7:0] x, y;
  logic [2:0] fsm_state;
  logic       b_dclk, b_din, b_cs_n, b_new_coord_r, b_penirq_n_o, b_transmit_en;
  logic [7:0] xb, yb;
  logic [2:0] b_fsm_state;

  touch_adc_spi #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .RELEASE(RELEASE),
    .SAMPLE_GAP(SAMPLE_GAP), .PULSE_W(PULSE_W), .INV_X(0), .INV_Y(0)
  ) dut (
    .sys_clk(sys_clk), .iRST_n(iRST_n), .adc_penirq_n(adc_penirq_n),
    .adc_dout(adc_dout), .adc_dclk(adc_dclk), .adc_din(adc_din),
    .adc_cs_n(adc_cs_n), .x(x), .y(y), .new_coord_r(new_coord_r),
    .penirq_n_o(penirq_n_o), .transmit_en(transmit_en), .fsm_state(fsm_state)
  );

  touch_adc_spi #(
    .CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE), .RELEASE(RELEASE),
    .SAMPLE_GAP(SAMPLE_GAP), .PULSE_W(PULSE_W), .INV_X(1), .INV_Y(0)
  ) dut_inv (
    .sys_clk(sys_clk), .iRST_n(iRST_n), .adc_penirq_n(adc_penirq_n),
    .adc_dout(adc_dout), .adc_dclk(b_dclk), .adc_din(b_din),
    .adc_cs_n(b_cs_n), .x(xb), .y(yb), .new_coord_r(b_new_coord_r),
    .penirq_n_o(b_penirq_n_o), .transmit_en(b_transmit_en), .fsm_state(b_fsm_state)
  );

  // ---------------- scoreboard state ----------------
  vec_t       vec [NV];
  vec_t       exp_q[$];
  logic [7:0] exp_cmd_q[$];
  int         n_total = 0;
  int         n_pass  = 0;
  int         cyc = 0;
  int         pub_cnt = 0;
  int         pen_falls = 0;
  int         te_falls = 0;
  int         te_rise_cyc = -1;
  int         atomic_viol = 0;
  int         lockstep_viol = 0;
  int         last_pub = 0;
  bit         spacing_armed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- ADC model ----------------
  int         rise_cnt = 0;
  logic [7:0] cmd_sh = 8'h00;
  logic [7:0] resp = 8'h00;

  always @(negedge adc_cs_n) rise_cnt = 0;

  always @(posedge adc_dclk) begin
    logic [7:0] exp_c;
    rise_cnt++;
    if (rise_cnt <= 8) cmd_sh = {cmd_sh[6:0], adc_din};
    if (rise_cnt == 8) begin
      exp_c = (exp_cmd_q.size() != 0) ? exp_cmd_q.pop_front() : 8'h00;
      check("adc_cmd", cmd_sh, exp_c);
    end
  end

  always @(negedge adc_dclk) begin
    int vi;
    vi = (pub_cnt < NV) ? pub_cnt : NV - 1;
    if (rise_cnt == 9) resp = (cmd_sh == 8'hD8) ? vec[vi].rx : vec[vi].ry;
    if (rise_cnt >= 9 && rise_cnt <= 16) adc_dout = resp[16 - rise_cnt];
    else adc_dout = 1'b0;
  end

  // ---------------- per-cycle watchers ----------------
  always @(posedge sys_clk) cyc++;

  logic [7:0] px = 8'h00, py = 8'h00;
  logic       p_pen = 1'b1, p_te = 1'b0;

  always begin
    @(posedge sys_clk); #1;
    if (iRST_n && !new_coord_r && (x !== px || y !== py)) atomic_viol++;
    if (p_pen && !penirq_n_o) pen_falls++;
    if (p_te && !transmit_en) te_falls++;
    if (!p_te && transmit_en) te_rise_cyc = cyc;
    if (adc_dclk !== b_dclk || adc_din !== b_din || adc_cs_n !== b_cs_n ||
        new_coord_r !== b_new_coord_r || penirq_n_o !== b_penirq_n_o ||
        transmit_en !== b_transmit_en || fsm_state !== b_fsm_state) lockstep_viol++;
    px = x; py = y; p_pen = penirq_n_o; p_te = transmit_en;
  end

  // ---------------- publish monitor (pops scoreboard) ----------------
  always begin
    vec_t e;
    int   w;
    bit   starts_next;
    @(posedge sys_clk); #2;
    if (iRST_n && new_coord_r) begin
      check("te_at_pub", transmit_en, 1);
      check("penirq_at_pub", penirq_n_o, 1);
      check("frame_rises", rise_cnt, 17);
      if (pub_cnt == 0) check("te_rise_cycle", te_rise_cyc, cyc);
      if (spacing_armed) check("pub_spacing", cyc - last_pub, PERIOD);
      spacing_armed = 1;
      last_pub = cyc;
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("x", x, e.ex);
        check("y", y, e.ey);
        check("x_inv", xb, e.exi);
        check("y_inv_off", yb, e.ey);
      end
      pub_cnt++;
      w = 0;
      @(posedge sys_clk); #2;
      starts_next = (penirq_n_o == 1'b0);
      while (penirq_n_o == 1'b0 && w < 40) begin
        w++;
        @(posedge sys_clk); #2;
      end
      check("strobe_width", starts_next ? w : 0, PULSE_W);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pub(input int target, input int budget);
    int n = 0;
    while (pub_cnt < target && n < budget) begin
      @(posedge sys_clk); #3;
      n++;
    end
    check("pub_wait", pub_cnt >= target, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cs_n"}, adc_cs_n, 1);
    check({tag, "_dclk"}, adc_dclk, 0);
    check({tag, "_din"}, adc_din, 0);
    check({tag, "_x"}, x, 0);
    check({tag, "_y"}, y, 0);
    check({tag, "_new_coord"}, new_coord_r, 0);
    check({tag, "_penirq"}, penirq_n_o, 1);
    check({tag, "_te"}, transmit_en, 0);
    check({tag, "_state"}, fsm_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cs_low;
    int snap;
    int n;

    vec[0] = '{rx: 8'h5A, ry: 8'hC3, ex: 8'h5A, ey: 8'hC3, exi: 8'hA5};
    vec[1] = '{rx: 8'h10, ry: 8'h00, ex: 8'h10, ey: 8'h00, exi: 8'hEF};
    vec[2] = '{rx: 8'hFF, ry: 8'h01, ex: 8'hFF, ey: 8'h01, exi: 8'h00};
    vec[3] = '{rx: 8'h00, ry: 8'hFF, ex: 8'h00, ey: 8'hFF, exi: 8'hFF};
    vec[4] = '{rx: 8'h81, ry: 8'h7E, ex: 8'h81, ey: 8'h7E, exi: 8'h7E};

    iRST_n = 1'b0;
    adc_penirq_n = 1'b1;
    adc_dout = 1'b0;
    repeat (5) @(negedge sys_clk);
    iRST_n = 1'b1;
    repeat (3) @(posedge sys_clk);
    #3;
    check_idle_outputs("reset");

    // Bounce: 5 low cycles, shorter than DEBOUNCE.
    @(negedge sys_clk) adc_penirq_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    adc_penirq_n = 1'b1;
    cs_low = 0;
    repeat (60) begin
      @(posedge sys_clk); #3;
      if (!adc_cs_n || transmit_en) cs_low++;
    end
    check("bounce_no_frame", cs_low, 0);
    check("bounce_state", fsm_state, 0);
    check("bounce_te", transmit_en, 0);

    // Continuous hold, table-driven: one sample per table entry.
    spacing_armed = 0;
    @(negedge sys_clk) adc_penirq_n = 1'b0;
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vec[i]);
      exp_cmd_q.push_back(8'hD8);
      exp_cmd_q.push_back(8'h98);
      wait_pub(i + 1, 2000);
      if (i == 1) begin
        // 49-cycle pen-up glitch inside the gap must not end the session.
        @(negedge sys_clk) adc_penirq_n = 1'b1;
        repeat (49) @(negedge sys_clk);
        adc_penirq_n = 1'b0;
        repeat (5) @(posedge sys_clk);
        #3;
        check("glitch_te", transmit_en, 1);
        check("glitch_state_gap", fsm_state, 5);
      end
    end

    // Release: pen up in the PUBLISH cycle; session ends 50 cycles after
    // the synchronized rise (2 edges after the drive).
    @(negedge sys_clk) adc_penirq_n = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      @(posedge sys_clk); #3;
      if (k == 51) check("release_te_before", transmit_en, 1);
      if (k == 52) begin
        check("release_te_after", transmit_en, 0);
        check("release_penirq", penirq_n_o, 1);
        check("release_cs_n", adc_cs_n, 1);
        check("release_state", fsm_state, 0);
        check("release_x_hold", x, vec[NV-1].ex);
        check("release_y_hold", y, vec[NV-1].ey);
      end
    end
    spacing_armed = 0;
    repeat (20) @(posedge sys_clk);

    // Reset in the middle of CONV_X, around command bit 5.
    @(negedge sys_clk) adc_penirq_n = 1'b0;
    n = 0;
    while (!(rise_cnt == 5 && adc_cs_n == 1'b0) && n < 1000) begin
      @(posedge sys_clk); #3;
      n++;
    end
    check("midframe_reached", rise_cnt == 5 && adc_cs_n == 1'b0, 1);
    check("midframe_state", fsm_state, 2);
    @(negedge sys_clk) iRST_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    adc_penirq_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    iRST_n = 1'b1;
    snap = pub_cnt;
    cs_low = 0;
    repeat (400) begin
      @(posedge sys_clk); #3;
      if (!adc_cs_n) cs_low++;
    end
    check("post_reset_no_frame", cs_low, 0);
    check("post_reset_no_pub", pub_cnt, snap);

    // Totals.
    check("pub_count", pub_cnt, NV);
    check("penirq_falls", pen_falls, NV);
    check("te_falls", te_falls, 1);
    check("atomic_xy", atomic_viol, 0);
    check("lockstep", lockstep_viol, 0);
    check("exp_q_empty", exp_q.size(), 0);
    check("cmd_q_empty", exp_cmd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
